// File: rtl/dk_multi_walk_voice_pkg.sv
// Shared types and helpers for the discrete-sound voice blocks.
// Signal scale: SIGNAL_FRACTION_WIDTH fraction bits, full scale equals VCC.
package dk_discrete_pkg;

  localparam int SIGNAL_WIDTH          = 16;
  localparam int SIGNAL_FRACTION_WIDTH = 14;
  localparam int VCC_MV                = 12000;
  localparam int SIG_MAX               = (1 << (SIGNAL_WIDTH - 1)) - 1;
  localparam int SIG_MIN               = -(1 << (SIGNAL_WIDTH - 1));

  typedef logic signed [SIGNAL_WIDTH-1:0] signal_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_e;

  function automatic signal_t voltage_to_signal(input int millivolts);
    return signal_t'((millivolts << SIGNAL_FRACTION_WIDTH) / VCC_MV);
  endfunction

  function automatic signal_t sat_to_signal(input logic signed [31:0] x);
    signal_t y;
    if (x > SIG_MAX) begin
      y = signal_t'(SIG_MAX);
    end else if (x < SIG_MIN) begin
      y = signal_t'(SIG_MIN);
    end else begin
      y = x[SIGNAL_WIDTH-1:0];
    end
    return y;
  endfunction

endpackage

// File: rtl/dk_multi_walk_voice_if.sv
// Sample-strobe, trigger and audio-result bundle of the multi-channel walk voice.
interface dk_multi_walk_voice_if
  import dk_discrete_pkg::*;
#(
  parameter int NUM_CH = 4
);

  logic              audio_clk_en;
  logic [NUM_CH-1:0] walk_en;
  signal_t           ch_out [NUM_CH];
  signal_t           mix_out;
  logic              sample_valid;
  logic              busy;
  logic              overrun;

  modport master (
    output audio_clk_en,
    output walk_en,
    input  ch_out,
    input  mix_out,
    input  sample_valid,
    input  busy,
    input  overrun
  );

  modport slave (
    input  audio_clk_en,
    input  walk_en,
    output ch_out,
    output mix_out,
    output sample_valid,
    output busy,
    output overrun
  );

endinterface

// File: rtl/dk_multi_walk_voice_step.sv
// One channel sample step: slewed level -> VCO phase -> gated high-pass envelope -> diode gain.
// Purely combinational; the caller owns the per-channel state.
module dk_voice_channel_step
  import dk_discrete_pkg::*;
#(
  parameter int LEVEL_HI       = 6826,
  parameter int SLEW_STEP      = 27,
  parameter int PHASE_WIDTH    = 24,
  parameter int VCO_BASE_INC   = 4000,
  parameter int VCO_GAIN_SHIFT = 2,
  parameter int ENV_SHIFT      = 3,
  parameter int POS_SHIFT      = 1,
  parameter int NEG_SHIFT_A    = 1,
  parameter int NEG_SHIFT_B    = 2
) (
  input  signal_t                        level,
  input  logic signed [SIGNAL_WIDTH+1:0] env,
  input  logic [PHASE_WIDTH-1:0]         phase,
  input  logic                           en,
  output signal_t                        level_nxt,
  output logic signed [SIGNAL_WIDTH+1:0] env_nxt,
  output logic [PHASE_WIDTH-1:0]         phase_nxt,
  output signal_t                        result
);

  localparam int LW = SIGNAL_WIDTH + 1;
  localparam int EW = SIGNAL_WIDTH + 2;
  localparam int RW = SIGNAL_WIDTH + 3;
  localparam logic signed [LW-1:0] LEVEL_HI_S = LW'(LEVEL_HI);
  localparam logic signed [LW-1:0] SLEW_S     = LW'(SLEW_STEP);

  logic signed [LW-1:0] level_ext_s;
  logic signed [LW-1:0] target_s;
  logic signed [LW-1:0] diff_s;
  logic signed [LW-1:0] lvl_s;
  logic signed [LW-1:0] delta_s;
  logic signed [LW-1:0] vco_s;
  logic signed [RW-1:0] gated_s;
  logic signed [RW-1:0] gain_s;

  // Level/VCO/envelope/gain chain evaluated for the channel currently selected
  always_comb begin
    level_ext_s = {level[SIGNAL_WIDTH-1], level};
    if (en) begin
      target_s = {LW{1'b0}};
    end else begin
      target_s = LEVEL_HI_S;
    end
    diff_s = target_s - level_ext_s;
    // Clamp the move so the level lands exactly on target on the last step
    if (diff_s > SLEW_S) begin
      lvl_s = level_ext_s + SLEW_S;
    end else if (diff_s < -SLEW_S) begin
      lvl_s = level_ext_s - SLEW_S;
    end else begin
      lvl_s = target_s;
    end
    delta_s   = lvl_s - level_ext_s;
    level_nxt = lvl_s[SIGNAL_WIDTH-1:0];
    env_nxt   = env - (env >>> ENV_SHIFT) + EW'(delta_s);
    vco_s     = (LEVEL_HI_S - lvl_s) >>> VCO_GAIN_SHIFT;
    phase_nxt = phase + PHASE_WIDTH'(VCO_BASE_INC) + PHASE_WIDTH'(vco_s[SIGNAL_WIDTH-1:0]);
    if (phase[PHASE_WIDTH-1]) begin
      gated_s = {RW{1'b0}};
    end else begin
      gated_s = RW'(env_nxt);
    end
    if (!gated_s[RW-1] && (gated_s != {RW{1'b0}})) begin
      gain_s = gated_s + (gated_s >>> POS_SHIFT);
    end else begin
      gain_s = (gated_s >>> NEG_SHIFT_A) + (gated_s >>> NEG_SHIFT_B);
    end
    result = sat_to_signal(32'(gain_s));
  end

endmodule

// File: rtl/dk_multi_walk_voice.sv
// N-channel walk voice: one shared step datapath visits every channel once per audio sample,
// then publishes all channel results and their saturated mix together.
module dk_multi_walk_voice
  import dk_discrete_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int LEVEL_HI       = int'(voltage_to_signal(5000)),
  parameter int SLEW_STEP      = 27,
  parameter int PHASE_WIDTH    = 24,
  parameter int VCO_BASE_INC   = 4000,
  parameter int VCO_GAIN_SHIFT = 2,
  parameter int ENV_SHIFT      = 3,
  parameter int POS_SHIFT      = 1,
  parameter int NEG_SHIFT_A    = 1,
  parameter int NEG_SHIFT_B    = 2
) (
  input logic                  clk,
  input logic                  I_RST,
  dk_multi_walk_voice_if.slave bus
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int MIX_W = SIGNAL_WIDTH + $clog2(NUM_CH) + 1;
  localparam int EW    = SIGNAL_WIDTH + 2;

  fsm_state_e                 state_r;
  logic [IDX_W-1:0]           ch_idx_r;
  logic [NUM_CH-1:0]          en_q_r;
  signal_t                    level_r   [NUM_CH];
  logic signed [EW-1:0]       env_r     [NUM_CH];
  logic [PHASE_WIDTH-1:0]     phase_r   [NUM_CH];
  signal_t                    res_buf_r [NUM_CH];
  logic signed [MIX_W-1:0]    mix_acc_r;

  signal_t                    level_nxt_s;
  logic signed [EW-1:0]       env_nxt_s;
  logic [PHASE_WIDTH-1:0]     phase_nxt_s;
  signal_t                    result_s;

  dk_voice_channel_step #(
    .LEVEL_HI       (LEVEL_HI),
    .SLEW_STEP      (SLEW_STEP),
    .PHASE_WIDTH    (PHASE_WIDTH),
    .VCO_BASE_INC   (VCO_BASE_INC),
    .VCO_GAIN_SHIFT (VCO_GAIN_SHIFT),
    .ENV_SHIFT      (ENV_SHIFT),
    .POS_SHIFT      (POS_SHIFT),
    .NEG_SHIFT_A    (NEG_SHIFT_A),
    .NEG_SHIFT_B    (NEG_SHIFT_B)
  ) u_step (
    .level     (level_r[ch_idx_r]),
    .env       (env_r[ch_idx_r]),
    .phase     (phase_r[ch_idx_r]),
    .en        (en_q_r[ch_idx_r]),
    .level_nxt (level_nxt_s),
    .env_nxt   (env_nxt_s),
    .phase_nxt (phase_nxt_s),
    .result    (result_s)
  );

  // Scheduler FSM, per-channel state update and registered outputs
  always_ff @(posedge clk) begin
    if (I_RST) begin
      state_r          <= IDLE;
      ch_idx_r         <= {IDX_W{1'b0}};
      en_q_r           <= {NUM_CH{1'b0}};
      mix_acc_r        <= {MIX_W{1'b0}};
      bus.mix_out      <= {SIGNAL_WIDTH{1'b0}};
      bus.sample_valid <= 1'b0;
      bus.busy         <= 1'b0;
      bus.overrun      <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        level_r[c]    <= signal_t'(LEVEL_HI);
        env_r[c]      <= {EW{1'b0}};
        phase_r[c]    <= {PHASE_WIDTH{1'b0}};
        res_buf_r[c]  <= {SIGNAL_WIDTH{1'b0}};
        bus.ch_out[c] <= {SIGNAL_WIDTH{1'b0}};
      end
    end else begin
      bus.sample_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.audio_clk_en) begin
            state_r   <= RUN;
            ch_idx_r  <= {IDX_W{1'b0}};
            en_q_r    <= bus.walk_en;
            mix_acc_r <= {MIX_W{1'b0}};
            bus.busy  <= 1'b1;
          end
        end
        RUN: begin
          level_r[ch_idx_r]   <= level_nxt_s;
          env_r[ch_idx_r]     <= env_nxt_s;
          phase_r[ch_idx_r]   <= phase_nxt_s;
          res_buf_r[ch_idx_r] <= result_s;
          mix_acc_r           <= mix_acc_r + MIX_W'(result_s);
          if (ch_idx_r == IDX_W'(NUM_CH - 1)) begin
            state_r <= DONE;
          end else begin
            ch_idx_r <= ch_idx_r + IDX_W'(1);
          end
          if (bus.audio_clk_en) begin
            bus.overrun <= 1'b1;
          end
        end
        DONE: begin
          for (int c = 0; c < NUM_CH; c++) begin
            bus.ch_out[c] <= res_buf_r[c];
          end
          bus.mix_out      <= sat_to_signal(32'(mix_acc_r));
          bus.sample_valid <= 1'b1;
          bus.busy         <= 1'b0;
          state_r          <= IDLE;
          if (bus.audio_clk_en) begin
            bus.overrun <= 1'b1;
          end
        end
        default: begin
          state_r  <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
